// File: rtl/lfsr_checker.sv
// Receive-side LFSR sequence checker: self-synchronises to the generator stream,
// declares lock, then flags and counts every bit that deviates from the prediction.
module lfsr_checker #(
  parameter int                    Shift_bits  = 4,
  parameter logic [Shift_bits-1:0] TAPS        = 4'b0011,
  parameter int                    LOCK_THRESH = 8,
  parameter int                    LOSS_THRESH = 4,
  parameter int                    CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_BIT,
  input  logic             IN_VALID,
  input  logic             CLR_CNT,
  output logic             LOCKED,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int FW = $clog2(Shift_bits + 1);
  localparam int GW = $clog2(LOCK_THRESH + 1);
  localparam int BW = $clog2(LOSS_THRESH + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(Shift_bits - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_THRESH - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {FILL, VERIFY, LOCK} state_t;

  state_t                state_p1, state_nxt;
  logic [Shift_bits-1:0] window_p1;
  logic [FW-1:0]         fill_cnt_p1;
  logic [GW-1:0]         good_cnt_p1;
  logic [BW-1:0]         bad_cnt_p1;
  logic                  pred, mismatch, win_zero;
  logic                  fill_done, good_done, bad_done;
  logic                  locked_nxt, err_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The window holds the last N bits, which equals the generator state N steps
  // back, so its feedback is exactly the next bit the generator emits.
  assign pred      = ^(window_p1 & TAPS);
  assign mismatch  = IN_BIT != pred;
  assign win_zero  = window_p1 == '0;
  assign fill_done = fill_cnt_p1 == FILL_LAST;
  assign good_done = good_cnt_p1 == GOOD_LAST;
  assign bad_done  = bad_cnt_p1 == BAD_LAST;

  always_comb begin
    state_nxt = state_p1;
    if (IN_VALID) begin
      case (state_p1)
        FILL:    if (fill_done) state_nxt = VERIFY;
        VERIFY:  if (!mismatch && !win_zero && good_done) state_nxt = LOCK;
        LOCK:    if (mismatch && bad_done) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_comb begin
    locked_nxt = state_nxt == LOCK;
    err_nxt    = IN_VALID && (state_p1 == LOCK) && mismatch;
  end

  // Stage p1: state and registered status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p1 <= FILL;
      LOCKED   <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      LOCKED   <= locked_nxt;
      ERR      <= err_nxt;
    end
  end

  // Stage p1: window, run-length counters and error count
  always_ff @(posedge CLK) begin
    if (RST) begin
      window_p1   <= '0;
      fill_cnt_p1 <= '0;
      good_cnt_p1 <= '0;
      bad_cnt_p1  <= '0;
      ERR_CNT     <= '0;
    end else begin
      if (CLR_CNT) ERR_CNT <= err_nxt ? CNT_W'(1) : '0;
      else if (err_nxt) ERR_CNT <= sat_inc(ERR_CNT);
      if (IN_VALID) begin
        case (state_p1)
          FILL: begin
            window_p1   <= {IN_BIT, window_p1[Shift_bits-1:1]};
            fill_cnt_p1 <= fill_done ? '0 : fill_cnt_p1 + 1'b1;
            good_cnt_p1 <= '0;
            bad_cnt_p1  <= '0;
          end
          VERIFY: begin
            window_p1   <= {IN_BIT, window_p1[Shift_bits-1:1]};
            fill_cnt_p1 <= '0;
            bad_cnt_p1  <= '0;
            if (!mismatch && !win_zero) good_cnt_p1 <= good_done ? '0 : good_cnt_p1 + 1'b1;
            else good_cnt_p1 <= '0;
          end
          LOCK: begin
            // Flywheel on the prediction so a corrupted bit never enters the window.
            window_p1   <= {pred, window_p1[Shift_bits-1:1]};
            fill_cnt_p1 <= '0;
            good_cnt_p1 <= '0;
            if (mismatch) bad_cnt_p1 <= bad_done ? '0 : bad_cnt_p1 + 1'b1;
            else bad_cnt_p1 <= '0;
          end
          default: begin
            window_p1   <= '0;
            fill_cnt_p1 <= '0;
            good_cnt_p1 <= '0;
            bad_cnt_p1  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default instance plus a CNT_W=2 instance sharing
// the same stimulus; expectations are queued per driven step and compared after the edge.
module tb_lfsr_checker;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_BIT = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        CLR_CNT = 1'b0;
  logic        locked, err;
  logic [15:0] err_cnt;
  logic        locked2, err2;
  logic [1:0]  err_cnt2;

  lfsr_checker dut (
    .CLK(CLK), .RST(RST), .IN_BIT(IN_BIT), .IN_VALID(IN_VALID), .CLR_CNT(CLR_CNT),
    .LOCKED(locked), .ERR(err), .ERR_CNT(err_cnt)
  );

  lfsr_checker #(.CNT_W(2)) dut_sat (
    .CLK(CLK), .RST(RST), .IN_BIT(IN_BIT), .IN_VALID(IN_VALID), .CLR_CNT(CLR_CNT),
    .LOCKED(locked2), .ERR(err2), .ERR_CNT(err_cnt2)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        l;
    logic        e;
    logic [15:0] c;
    logic [1:0]  c2;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          gi = 0;
  int          cnt = 0;
  logic [14:0] pat;

  task automatic gen(output logic b);
    b  = pat[gi % 15];
    gi = gi + 1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic v, input logic clr,
                      input logic el, input logic ee, input string tag);
    exp_t x;
    x.l  = el;
    x.e  = ee;
    x.c  = 16'(cnt);
    x.c2 = (cnt > 3) ? 2'd3 : 2'(cnt);
    exp_q.push_back(x);
    IN_BIT   = b;
    IN_VALID = v;
    CLR_CNT  = clr;
    @(posedge CLK);
    #1;
    x = exp_q.pop_front();
    check({tag, "/locked"},  16'(locked),   16'(x.l));
    check({tag, "/err"},     16'(err),      16'(x.e));
    check({tag, "/err_cnt"}, err_cnt,       x.c);
    check({tag, "/sat_cnt"}, 16'(err_cnt2), 16'(x.c2));
    check({tag, "/locked2"}, 16'(locked2),  16'(x.l));
  endtask

  initial begin
    logic b;
    int   nv;
    pat = 15'b000111101011001;

    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    RST = 1'b0;
    for (int i = 0; i < 6; i++) step(1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Clean acquisition and long locked run
    for (int n = 1; n <= 312; n++) begin
      gen(b);
      step(b, 1'b1, 1'b0, n >= 12, 1'b0, "acq");
    end

    // Single inverted bit while locked
    for (int k = 1; k <= 40; k++) begin
      gen(b);
      if (k == 20) begin
        b   = ~b;
        cnt = cnt + 1;
      end
      step(b, 1'b1, 1'b0, 1'b1, k == 20, "single");
    end

    // Four consecutive errors drop lock, then clean stream relocks
    for (int k = 1; k <= 4; k++) begin
      gen(b);
      cnt = cnt + 1;
      step(~b, 1'b1, 1'b0, k < 4, 1'b1, "loss");
    end
    for (int n = 1; n <= 16; n++) begin
      gen(b);
      step(b, 1'b1, 1'b0, n >= 12, 1'b0, "relock");
    end

    // Reset while locked, with CLR_CNT and an erroneous bit at the same edge
    RST = 1'b1;
    gen(b);
    cnt = 0;
    step(~b, 1'b1, 1'b1, 1'b0, 1'b0, "rst_lock");
    RST = 1'b0;

    // Gapped input: valid every other cycle
    nv = 0;
    for (int c = 0; c < 30; c++) begin
      if (c % 2 == 0) begin
        gen(b);
        nv = nv + 1;
        step(b, 1'b1, 1'b0, nv >= 12, 1'b0, "gap");
      end else begin
        step(1'($urandom_range(1, 0)), 1'b0, 1'b0, nv >= 12, 1'b0, "gap_idle");
      end
    end
    // Wrong bits without IN_VALID are ignored and leave the flywheel in phase
    for (int k = 0; k < 4; k++) step(~pat[gi % 15], 1'b0, 1'b0, 1'b1, 1'b0, "hold");
    for (int k = 0; k < 5; k++) begin
      gen(b);
      step(b, 1'b1, 1'b0, 1'b1, 1'b0, "hold_resume");
    end

    // All-zero stream never locks
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_zero");
    RST = 1'b0;
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "zeros");

    // Counter clear and saturation
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_cnt");
    RST = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      gen(b);
      step(b, 1'b1, 1'b0, n >= 12, 1'b0, "acq2");
    end
    gen(b); cnt = cnt + 1; step(~b, 1'b1, 1'b0, 1'b1, 1'b1, "e1");
    gen(b);                step(b,  1'b1, 1'b0, 1'b1, 1'b0, "e_gap");
    gen(b); cnt = cnt + 1; step(~b, 1'b1, 1'b0, 1'b1, 1'b1, "e2");
    gen(b); cnt = 0;       step(b,  1'b1, 1'b1, 1'b1, 1'b0, "clr");
    gen(b); cnt = 1;       step(~b, 1'b1, 1'b1, 1'b1, 1'b1, "clr_err");
    for (int k = 0; k < 5; k++) begin
      gen(b);
      step(b, 1'b1, 1'b0, 1'b1, 1'b0, "sat_gap");
      gen(b);
      cnt = cnt + 1;
      step(~b, 1'b1, 1'b0, 1'b1, 1'b1, "sat_err");
    end
    for (int k = 0; k < 3; k++) begin
      gen(b);
      step(b, 1'b1, 1'b0, 1'b1, 1'b0, "tail");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
